// File: rtl/display_pkg.sv
// display_pkg: scheduler states, segment codes and the display limit for agendador_display
package display_pkg;
  typedef enum logic [1:0] {IDLE, CONVERTE, ESCREVE, MOSTRA} estado_t;
  localparam logic [6:0] SEG_DIGITO [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_TRACO = 7'b0111111;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam int LIMITE_DISPLAY = 9999;
  function automatic logic [6:0] seg_digito(input logic [3:0] d);
    return d > 4'd9 ? SEG_TRACO : SEG_DIGITO[d];
  endfunction
endpackage

// File: rtl/agendador_display_if.sv
// agendador_display_if: two value sources (valor/valido) in; HEX3..HEX0, fonte_ativa, ocupado out
interface agendador_display_if;
  logic [15:0] valor_a;
  logic valido_a;
  logic [15:0] valor_b;
  logic valido_b;
  logic [6:0] HEX3;
  logic [6:0] HEX2;
  logic [6:0] HEX1;
  logic [6:0] HEX0;
  logic fonte_ativa;
  logic ocupado;
  modport master (output valor_a, valido_a, valor_b, valido_b, input HEX3, HEX2, HEX1, HEX0, fonte_ativa, ocupado);
  modport slave (input valor_a, valido_a, valor_b, valido_b, output HEX3, HEX2, HEX1, HEX0, fonte_ativa, ocupado);
endinterface

// File: rtl/conversor_bcd.sv
// conversor_bcd: 16-step double dabble; inicio loads valor (doing step 1), pronto pulses after step 16, bcd = 5 digits
module conversor_bcd (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [15:0] valor,
  output logic        pronto,
  output logic [19:0] bcd
);
  logic [35:0] sr;
  logic [3:0] passo;
  logic ativo;
  logic [19:0] ajustado;
  always_comb begin
    ajustado = sr[35:16];
    for (int i = 0; i < 5; i++)
      ajustado[4*i +: 4] = sr[16+4*i +: 4] >= 4'd5 ? sr[16+4*i +: 4] + 4'd3 : sr[16+4*i +: 4];
  end
  always_ff @(posedge clock)
    if (reset) begin
      sr <= '0;
      passo <= '0;
      ativo <= 1'b0;
      pronto <= 1'b0;
    end else if (inicio) begin
      sr <= {19'd0, valor, 1'b0};
      passo <= 4'd1;
      ativo <= 1'b1;
      pronto <= 1'b0;
    end else if (ativo) begin
      sr <= {ajustado[18:0], sr[15:0], 1'b0};
      passo <= passo + 4'd1;
      pronto <= passo == 4'd15;
      ativo <= passo != 4'd15;
    end else
      pronto <= 1'b0;
  assign bcd = sr[35:16];
endmodule

// File: rtl/agendador_display.sv
// agendador_display: time-shares HEX3..HEX0 between sources A/B with a dwell period; ports clock, reset, bus (slave)
module agendador_display
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input logic clock,
  input logic reset,
  agendador_display_if.slave bus
);
  localparam int CW = DWELL_CYCLES > 2 ? $clog2(DWELL_CYCLES) : 1;
  estado_t estado;
  logic [15:0] guarda_a, guarda_b, instantaneo, valor_conv;
  logic tem_a, tem_b, pend_a, pend_b, fonte, ocupado;
  logic [CW-1:0] conta;
  logic [27:0] imagem;
  logic inicio, alvo, expira, outra_tem, pend_atual, pronto, traco;
  logic [19:0] bcd;
  conversor_bcd conv (.clock(clock), .reset(reset), .inicio(inicio), .valor(valor_conv), .pronto(pronto), .bcd(bcd));
  always_comb begin
    expira = conta == CW'(DWELL_CYCLES - 1);
    outra_tem = fonte ? tem_a : tem_b;
    pend_atual = fonte ? pend_b : pend_a;
    inicio = estado == IDLE ? (tem_a | tem_b) : estado == MOSTRA ? (pend_atual | (expira & outra_tem)) : 1'b0;
    alvo = estado == IDLE ? !tem_a : (estado == MOSTRA && expira && outra_tem) ? !fonte : fonte;
    valor_conv = alvo ? guarda_b : guarda_a;
    traco = bcd[19:16] != 4'd0 || instantaneo > 16'(LIMITE_DISPLAY);
  end
  always_ff @(posedge clock)
    if (reset) begin
      estado <= IDLE;
      guarda_a <= '0;
      guarda_b <= '0;
      instantaneo <= '0;
      tem_a <= 1'b0;
      tem_b <= 1'b0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      fonte <= 1'b0;
      ocupado <= 1'b0;
      conta <= '0;
      imagem <= {4{SEG_APAGADO}};
    end else begin
      if (bus.valido_a) guarda_a <= bus.valor_a;
      if (bus.valido_b) guarda_b <= bus.valor_b;
      tem_a <= tem_a | bus.valido_a;
      tem_b <= tem_b | bus.valido_b;
      // a strobe landing on the entry edge survives the clear, so it is reconverted later
      pend_a <= (pend_a & !(inicio & !alvo)) | bus.valido_a;
      pend_b <= (pend_b & !(inicio & alvo)) | bus.valido_b;
      if (inicio) begin
        estado <= CONVERTE;
        fonte <= alvo;
        instantaneo <= valor_conv;
        conta <= '0;
        ocupado <= 1'b1;
      end else
        case (estado)
          CONVERTE: if (pronto) begin
            estado <= ESCREVE;
            ocupado <= 1'b0;
            imagem <= traco ? {4{SEG_TRACO}} :
              {seg_digito(bcd[15:12]), seg_digito(bcd[11:8]), seg_digito(bcd[7:4]), seg_digito(bcd[3:0])};
          end
          ESCREVE: estado <= MOSTRA;
          MOSTRA: conta <= expira ? '0 : conta + 1'b1;
          default: ;
        endcase
    end
  assign bus.HEX3 = imagem[27:21];
  assign bus.HEX2 = imagem[20:14];
  assign bus.HEX1 = imagem[13:7];
  assign bus.HEX0 = imagem[6:0];
  assign bus.fonte_ativa = fonte;
  assign bus.ocupado = ocupado;
endmodule

// File: tb/tb_agendador_display.sv
// tb_agendador_display: directed vector table plus multi-cycle sequences for agendador_display with DWELL_CYCLES = 8
module tb_agendador_display;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000, S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] ST = 7'b0111111;
  localparam logic [27:0] BLANK = {4{7'b1111111}};
  typedef struct {
    logic src;
    logic [15:0] v;
    logic [27:0] img;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int erros = 0;
  vec_t tab [12];
  logic [27:0] img;
  agendador_display_if bus ();
  agendador_display #(.DWELL_CYCLES(8)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  assign img = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      erros++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus.valido_a = 1'b0;
    bus.valido_b = 1'b0;
    bus.valor_a = '0;
    bus.valor_b = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic strobe(input logic a, input logic b, input logic [15:0] va, input logic [15:0] vb);
    bus.valido_a = a;
    bus.valido_b = b;
    bus.valor_a = va;
    bus.valor_b = vb;
    tick;
    bus.valido_a = 1'b0;
    bus.valido_b = 1'b0;
  endtask
  task automatic espera(input string nome, input logic [27:0] exp, input int ciclos, input logic f);
    int n = 0;
    while (img !== exp && n < 200) begin
      tick;
      n++;
    end
    check({nome, " cycles"}, n, ciclos);
    check({nome, " img"}, img, exp);
    check({nome, " fonte"}, bus.fonte_ativa, f);
  endtask
  initial begin
    int n_oc;
    logic mudou;
    logic [27:0] antes;
    tab[0]  = '{1'b0, 16'd1234,  {S1, S2, S3, S4}};
    tab[1]  = '{1'b0, 16'd7,     {S0, S0, S0, S7}};
    tab[2]  = '{1'b0, 16'd9999,  {S9, S9, S9, S9}};
    tab[3]  = '{1'b0, 16'd10000, {ST, ST, ST, ST}};
    tab[4]  = '{1'b0, 16'd65535, {ST, ST, ST, ST}};
    tab[5]  = '{1'b0, 16'd0,     {S0, S0, S0, S0}};
    tab[6]  = '{1'b1, 16'd5,     {S0, S0, S0, S5}};
    tab[7]  = '{1'b1, 16'd8,     {S0, S0, S0, S8}};
    tab[8]  = '{1'b0, 16'd4096,  {S4, S0, S9, S6}};
    tab[9]  = '{1'b1, 16'd42,    {S0, S0, S4, S2}};
    tab[10] = '{1'b0, 16'd5678,  {S5, S6, S7, S8}};
    tab[11] = '{1'b1, 16'd9990,  {S9, S9, S9, S0}};
    do_reset;
    check("reset img", img, BLANK);
    check("reset ocupado", bus.ocupado, 0);
    check("reset fonte", bus.fonte_ativa, 0);
    mudou = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick;
      if (img !== BLANK || bus.ocupado !== 1'b0 || bus.fonte_ativa !== 1'b0) mudou = 1'b1;
    end
    check("idle quiet", mudou, 0);
    for (int i = 0; i < 12; i++) begin
      do_reset;
      strobe(!tab[i].src, tab[i].src, tab[i].v, tab[i].v);
      n_oc = 0;
      for (int k = 1; k <= 17; k++) begin
        tick;
        n_oc += int'(bus.ocupado);
        if (k == 16) check($sformatf("vec%0d before E0+17", i), img, BLANK);
      end
      check($sformatf("vec%0d img", i), img, tab[i].img);
      check($sformatf("vec%0d fonte", i), bus.fonte_ativa, tab[i].src);
      check($sformatf("vec%0d ocupado cycles", i), n_oc, 16);
    end
    do_reset;
    strobe(1'b1, 1'b0, 16'd7, 16'd0);
    tick;
    tick;
    strobe(1'b0, 1'b1, 16'd0, 16'd9999);
    espera("alt A1", {S0, S0, S0, S7}, 14, 1'b0);
    espera("alt B1", {S9, S9, S9, S9}, 25, 1'b1);
    espera("alt A2", {S0, S0, S0, S7}, 25, 1'b0);
    espera("alt B2", {S9, S9, S9, S9}, 25, 1'b1);
    do_reset;
    strobe(1'b1, 1'b1, 16'd5, 16'd8);
    espera("simul A", {S0, S0, S0, S5}, 17, 1'b0);
    espera("simul B", {S0, S0, S0, S8}, 25, 1'b1);
    do_reset;
    strobe(1'b1, 1'b0, 16'd1, 16'd0);
    tick;
    tick;
    tick;
    strobe(1'b1, 1'b0, 16'd42, 16'd0);
    espera("pend 1", {S0, S0, S0, S1}, 13, 1'b0);
    espera("pend 42", {S0, S0, S4, S2}, 18, 1'b0);
    antes = img;
    mudou = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (img !== antes || bus.ocupado !== 1'b0) mudou = 1'b1;
    end
    check("pend settle", mudou, 0);
    do_reset;
    strobe(1'b0, 1'b1, 16'd0, 16'd1234);
    for (int k = 0; k < 4; k++) tick;
    check("mid ocupado", bus.ocupado, 1);
    check("mid fonte", bus.fonte_ativa, 1);
    rst = 1'b1;
    tick;
    check("rst img", img, BLANK);
    check("rst ocupado", bus.ocupado, 0);
    check("rst fonte", bus.fonte_ativa, 0);
    rst = 1'b0;
    mudou = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (img !== BLANK || bus.ocupado !== 1'b0) mudou = 1'b1;
    end
    check("rst idle", mudou, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, erros);
    $finish;
  end
endmodule
